tenv_wishbone_arbiter2: RTL and testbench

Two-master to one-slave Wishbone (pipelined, with stall) arbiter for the test environment. It shares one 4-lane synchronous-RAM Wishbone slave between the CPU instruction-fetch port (m0) and data port (m1). It holds the grant for a whole master bus cycle, tracks outstanding requests, and drains late acks before re-arbitrating.

---
 rtl/tenv_wb_pkg.sv | 23 ++
 rtl/tenv_wishbone_arbiter2_if.sv | 19 +
 rtl/tenv_wb_outstanding_cnt.sv | 50 +++++
 rtl/tenv_wishbone_arbiter2.sv | 145 ++++++++++++++
 tb/tb_tenv_wishbone_arbiter2.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/tenv_wb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, grant codes
// and the width helper for the outstanding-request counter.
package tenv_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Bits needed to hold the value max_val itself (4 -> 3, 15 -> 4).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/tenv_wishbone_arbiter2_if.sv
// Pipelined Wishbone link. A request transfers on a cycle where cyc=1, stb=1
// and stall=0; each transferred request is answered later by exactly one ack.
interface tenv_wishbone_arbiter2_if #(
  parameter int WADDR = 10,
  parameter int WDATA = 32
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic [3:0]       sel;
  logic [WADDR-1:0] adr;
  logic [WDATA-1:0] dat_w;
  logic [WDATA-1:0] dat_r;
  logic             stall;
  logic             ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input stall, ack, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output stall, ack, dat_r);
endinterface

// File: rtl/tenv_wb_outstanding_cnt.sv
// Up/down counter of issued-but-unacked requests, saturating at 0 and MAX,
// with a sticky error flag for overflow attempts and acks with nothing pending.
module tenv_wb_outstanding_cnt
  import tenv_wb_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         full_o,
  output logic         empty_next_o,
  output logic         err_o
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;
  logic         full, empty;

  assign full  = (cnt_q == MAX_V);
  assign empty = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (dec_i && empty) err_d = 1'b1;
    if (inc_i && !dec_i && full) err_d = 1'b1;
    if (inc_i && !dec_i && !full) cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && !empty) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign full_o       = full;
  assign empty_next_o = (cnt_d == '0);
  assign err_o        = err_q;
endmodule

// File: rtl/tenv_wishbone_arbiter2.sv
// Two-master to one-slave pipelined Wishbone arbiter. The grant is held for a
// whole master bus cycle; late acks of an abandoned cycle are drained first.
module tenv_wishbone_arbiter2
  import tenv_wb_pkg::*;
#(
  parameter int WADDR      = 10,
  parameter int WDATA      = 32,
  parameter int MAX_OUT    = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  tenv_wishbone_arbiter2_if.slave           m0,
  tenv_wishbone_arbiter2_if.slave           m1,
  tenv_wishbone_arbiter2_if.master          s,
  output logic [1:0]                        gnt_o,
  output logic                              err_o,
  output state_e                            state_o,
  output logic [cnt_width(MAX_OUT)-1:0]     out_cnt_o
);
  localparam int CW = cnt_width(MAX_OUT);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             pick_m0;
  logic             g_m1, sel_cyc, sel_stb, s_cyc, s_stb, g_stall;
  logic             full, empty_next, issue;
  logic [WADDR-1:0] sel_adr;
  logic [WDATA-1:0] sel_dat;

  // Data-path mux follows the registered grant; with no grant m0 is passed
  // through but cyc/stb are held low, so the slave ignores it.
  assign g_m1    = gnt_q[1];
  assign sel_cyc = g_m1 ? m1.cyc : m0.cyc;
  assign sel_stb = g_m1 ? m1.stb : m0.stb;
  assign sel_adr = g_m1 ? m1.adr : m0.adr;
  assign sel_dat = g_m1 ? m1.dat_w : m0.dat_w;
  assign s.we    = g_m1 ? m1.we : m0.we;
  assign s.sel   = g_m1 ? m1.sel : m0.sel;
  assign s.adr   = sel_adr;
  assign s.dat_w = sel_dat;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    g_stall  = 1'b0;
    m0.stall = m0.stb;
    m1.stall = m1.stb;
    m0.ack   = 1'b0;
    m1.ack   = 1'b0;
    case (state_q)
      ST_BUSY: begin
        s_cyc   = sel_cyc;
        s_stb   = sel_cyc & sel_stb & ~full;
        g_stall = s.stall | (sel_stb & full);
        if (g_m1) begin
          m1.stall = g_stall;
          m1.ack   = s.ack;
        end else begin
          m0.stall = g_stall;
          m0.ack   = s.ack;
        end
      end
      // Abandoned cycle: keep cyc up so the slave can finish, swallow acks.
      ST_DRAIN: begin
        s_cyc    = 1'b1;
        m0.stall = 1'b1;
        m1.stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign s.cyc = s_cyc;
  assign s.stb = s_stb;
  assign issue = s_stb & ~s.stall;

  tenv_wb_outstanding_cnt #(.MAX(MAX_OUT), .W(CW)) u_cnt (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inc_i        (issue),
    .dec_i        (s.ack),
    .cnt_o        (out_cnt_o),
    .full_o       (full),
    .empty_next_o (empty_next),
    .err_o        (err_o)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    pick_m0 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0.cyc || m1.cyc) begin
          // last_q=1 means m1 won previously, so round-robin favours m0.
          if (m0.cyc && m1.cyc) pick_m0 = (FIXED_PRIO != 0) || last_q;
          else                  pick_m0 = m0.cyc;
          state_d = ST_BUSY;
          gnt_d   = pick_m0 ? GNT_M0 : GNT_M1;
          last_d  = ~pick_m0;
        end
      end
      ST_BUSY: begin
        if (!sel_cyc) begin
          if (empty_next) begin
            state_d = ST_IDLE;
            gnt_d   = GNT_NONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (empty_next) begin
          state_d = ST_IDLE;
          gnt_d   = GNT_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_NONE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_tenv_wishbone_arbiter2.sv
// Bench for tenv_wishbone_arbiter2: a round-robin instance driven from a vector
// table, and a fixed-priority MAX_OUT=2 instance driven by a pipelined slave model.
module tb_tenv_wishbone_arbiter2;
  import tenv_wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- DUT A: MAX_OUT=4, round-robin ----------------
  tenv_wishbone_arbiter2_if #(.WADDR(10), .WDATA(32)) a_m0 ();
  tenv_wishbone_arbiter2_if #(.WADDR(10), .WDATA(32)) a_m1 ();
  tenv_wishbone_arbiter2_if #(.WADDR(10), .WDATA(32)) a_s ();
  logic [1:0] a_gnt;
  logic       a_err;
  state_e     a_state;
  logic [2:0] a_cnt;

  tenv_wishbone_arbiter2 #(.WADDR(10), .WDATA(32), .MAX_OUT(4), .FIXED_PRIO(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .m0(a_m0), .m1(a_m1), .s(a_s),
    .gnt_o(a_gnt), .err_o(a_err), .state_o(a_state), .out_cnt_o(a_cnt)
  );

  // ---------------- DUT B: MAX_OUT=2, fixed priority ----------------
  tenv_wishbone_arbiter2_if #(.WADDR(10), .WDATA(32)) b_m0 ();
  tenv_wishbone_arbiter2_if #(.WADDR(10), .WDATA(32)) b_m1 ();
  tenv_wishbone_arbiter2_if #(.WADDR(10), .WDATA(32)) b_s ();
  logic [1:0] b_gnt;
  logic       b_err;
  state_e     b_state;
  logic [1:0] b_cnt;

  tenv_wishbone_arbiter2 #(.WADDR(10), .WDATA(32), .MAX_OUT(2), .FIXED_PRIO(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .m0(b_m0), .m1(b_m1), .s(b_s),
    .gnt_o(b_gnt), .err_o(b_err), .state_o(b_state), .out_cnt_o(b_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [9:0] adr);
    return 32'h5A5A_0000 | {22'd0, adr};
  endfunction

  // in  = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_stall, s_ack}
  // exp = {gnt[1:0], s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack, err, state[1:0]}
  typedef struct {
    logic [5:0]  in;
    logic [10:0] exp;
  } vec_t;
  vec_t vecs[27];

  logic [46:0] bus_m0, bus_m1;
  logic [2:0]  vld;
  logic [31:0] pdat[3];
  logic [31:0] idat;
  logic        issue, accepted, exp_stall, exp_sstb, exp_ack;
  int          sent, acked, pend;

  // ---------------- driver / test sequence ----------------
  initial begin
    a_m0.cyc = 0; a_m0.stb = 0; a_m0.we = 1'b0; a_m0.sel = 4'hF; a_m0.adr = 10'h011; a_m0.dat_w = 32'h0000_A0A0;
    a_m1.cyc = 0; a_m1.stb = 0; a_m1.we = 1'b1; a_m1.sel = 4'h3; a_m1.adr = 10'h122; a_m1.dat_w = 32'h0000_B1B1;
    a_s.stall = 0; a_s.ack = 0; a_s.dat_r = 32'hCAFE_0001;
    b_m0.cyc = 0; b_m0.stb = 0; b_m0.we = 0; b_m0.sel = 4'hF; b_m0.adr = 10'h000; b_m0.dat_w = '0;
    b_m1.cyc = 0; b_m1.stb = 0; b_m1.we = 0; b_m1.sel = 4'hF; b_m1.adr = 10'h200; b_m1.dat_w = '0;
    b_s.stall = 0; b_s.ack = 0; b_s.dat_r = '0;
    bus_m0 = {1'b0, 4'hF, 10'h011, 32'h0000_A0A0};
    bus_m1 = {1'b1, 4'h3, 10'h122, 32'h0000_B1B1};

    // Tie after reset (m0), m0 reads, m1 with slave stall, RR tie again,
    // m0 abandons 2 pending -> DRAIN, spurious ack -> sticky err.
    vecs[0]  = '{6'b000000, 11'b00_0_0_0_0_0_0_0_00};
    vecs[1]  = '{6'b111100, 11'b00_0_0_1_1_0_0_0_00};
    vecs[2]  = '{6'b111100, 11'b01_1_1_0_1_0_0_0_01};
    vecs[3]  = '{6'b101101, 11'b01_1_0_0_1_1_0_0_01};
    vecs[4]  = '{6'b001100, 11'b01_0_0_0_1_0_0_0_01};
    vecs[5]  = '{6'b001100, 11'b00_0_0_0_1_0_0_0_00};
    vecs[6]  = '{6'b001110, 11'b10_1_1_0_1_0_0_0_01};
    vecs[7]  = '{6'b001100, 11'b10_1_1_0_0_0_0_0_01};
    vecs[8]  = '{6'b001001, 11'b10_1_0_0_0_0_1_0_01};
    vecs[9]  = '{6'b110000, 11'b10_0_0_1_0_0_0_0_01};
    vecs[10] = '{6'b111100, 11'b00_0_0_1_1_0_0_0_00};
    vecs[11] = '{6'b111100, 11'b01_1_1_0_1_0_0_0_01};
    vecs[12] = '{6'b111100, 11'b01_1_1_0_1_0_0_0_01};
    vecs[13] = '{6'b001100, 11'b01_0_0_0_1_0_0_0_01};
    vecs[14] = '{6'b001101, 11'b01_1_0_1_1_0_0_0_10};
    vecs[15] = '{6'b001100, 11'b01_1_0_1_1_0_0_0_10};
    vecs[16] = '{6'b001101, 11'b01_1_0_1_1_0_0_0_10};
    vecs[17] = '{6'b001100, 11'b00_0_0_0_1_0_0_0_00};
    vecs[18] = '{6'b001000, 11'b10_1_0_0_0_0_0_0_01};
    vecs[19] = '{6'b000000, 11'b10_0_0_0_0_0_0_0_01};
    vecs[20] = '{6'b000001, 11'b00_0_0_0_0_0_0_0_00};
    vecs[21] = '{6'b000000, 11'b00_0_0_0_0_0_0_1_00};
    vecs[22] = '{6'b110000, 11'b00_0_0_1_0_0_0_1_00};
    vecs[23] = '{6'b110000, 11'b01_1_1_0_0_0_0_1_01};
    vecs[24] = '{6'b000001, 11'b01_0_0_0_0_1_0_1_01};
    vecs[25] = '{6'b000000, 11'b00_0_0_0_0_0_0_1_00};
    vecs[26] = '{6'b110000, 11'b00_0_0_1_0_0_0_1_00};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      {a_m0.cyc, a_m0.stb, a_m1.cyc, a_m1.stb, a_s.stall, a_s.ack} = vecs[i].in;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {a_gnt, a_s.cyc, a_s.stb, a_m0.stall, a_m1.stall, a_m0.ack, a_m1.ack, a_err, a_state},
            vecs[i].exp);
      if (vecs[i].exp[10:9] == GNT_M0)
        check($sformatf("vec%0d_bus_m0", i), {a_s.we, a_s.sel, a_s.adr, a_s.dat_w}, bus_m0);
      else if (vecs[i].exp[10:9] == GNT_M1)
        check($sformatf("vec%0d_bus_m1", i), {a_s.we, a_s.sel, a_s.adr, a_s.dat_w}, bus_m1);
      if (i == 0) begin
        check("rdata_m0_passthru", a_m0.dat_r, 32'hCAFE_0001);
        check("rdata_m1_passthru", a_m1.dat_r, 32'hCAFE_0001);
      end
    end

    // Asynchronous reset pulse between clock edges while m0 owns the bus.
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_gnt", a_gnt, GNT_M0);
    check("pre_rst_s_cyc", a_s.cyc, 1'b1);
    check("pre_rst_err", a_err, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt", a_gnt, GNT_NONE);
    check("async_rst_s_cyc", a_s.cyc, 1'b0);
    check("async_rst_s_stb", a_s.stb, 1'b0);
    check("async_rst_err", a_err, 1'b0);
    check("async_rst_state", a_state, ST_IDLE);
    #1 rst = 1'b0;
    a_m0.cyc = 0; a_m0.stb = 0;

    // m1 streams 6 reads into a 3-cycle slave with only 2 allowed pending.
    sent = 0; acked = 0; pend = 0; vld = '0;
    pdat[0] = '0; pdat[1] = '0; pdat[2] = '0;
    @(posedge clk);
    #1;
    b_m1.cyc = 1; b_m1.stb = 1; b_m1.adr = 10'h200;
    for (int c = 0; c < 80 && acked < 6; c++) begin
      @(negedge clk);
      exp_stall = (c == 0) ? b_m1.stb : (b_m1.stb && pend == 2);
      exp_sstb  = (c == 0) ? 1'b0 : (b_m1.stb && pend < 2);
      exp_ack   = (c == 0) ? 1'b0 : b_s.ack;
      check("stream_m1_stall", b_m1.stall, exp_stall);
      check("stream_s_stb", b_s.stb, exp_sstb);
      check("stream_m1_ack", b_m1.ack, exp_ack);
      if (c == 1) check("stream_gnt", b_gnt, GNT_M1);
      issue    = b_s.stb && !b_s.stall;
      idat     = slave_data(b_s.adr);
      accepted = b_m1.stb && !b_m1.stall;
      if (accepted) exp_q.push_back(slave_data(b_m1.adr));
      if (b_m1.ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_unexpected_ack: got ack expected none");
        end else begin
          check("stream_rdata", b_m1.dat_r, exp_q.pop_front());
        end
        acked++;
      end
      pend = pend + (issue ? 1 : 0) - (b_s.ack ? 1 : 0);
      @(posedge clk);
      #1;
      vld = {vld[1:0], issue};
      pdat[2] = pdat[1]; pdat[1] = pdat[0]; pdat[0] = idat;
      b_s.ack = vld[2];
      b_s.dat_r = pdat[2];
      if (accepted) begin
        sent++;
        b_m1.adr = 10'h200 + 10'(sent);
        if (sent == 6) b_m1.stb = 0;
      end
    end
    check("stream_ack_count", acked, 6);
    check("stream_queue_empty", exp_q.size(), 0);
    b_m1.cyc = 0;
    b_s.ack = 0;
    @(negedge clk);
    check("stream_final_cnt", b_cnt, 2'd0);
    check("stream_no_err", b_err, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stream_release_gnt", b_gnt, GNT_NONE);
    check("stream_release_state", b_state, ST_IDLE);

    // Fixed priority: m0 wins both ties, even right after it won the last one.
    b_m0.cyc = 1; b_m1.cyc = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fp_tie1_gnt", b_gnt, GNT_M0);
    @(posedge clk);
    #1;
    b_m0.cyc = 0; b_m1.cyc = 0;
    @(posedge clk);
    #1;
    check("fp_idle_gnt", b_gnt, GNT_NONE);
    b_m0.cyc = 1; b_m1.cyc = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fp_tie2_gnt", b_gnt, GNT_M0);
    b_m0.cyc = 0; b_m1.cyc = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
